// File: rtl/axil_slave_mem_if.sv
// AXI-Lite bus bundle between the DMA master and axil_slave_mem.
// The s_wstrb lane only exists when AXIL_MEM_STRB_EN is defined.
interface axil_slave_mem_if;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
`ifdef AXIL_MEM_STRB_EN
  logic [3:0]  s_wstrb;
`endif
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  modport master (
`ifdef AXIL_MEM_STRB_EN
    output s_wstrb,
`endif
    output s_araddr, s_arvalid, s_rready,
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
`ifdef AXIL_MEM_STRB_EN
    input  s_wstrb,
`endif
    input  s_araddr, s_arvalid, s_rready,
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axil_slave_mem.sv
// AXI-Lite slave scratch memory with programmable read/write wait states.
// Independent read and write FSMs; out-of-window or misaligned accesses
// answer SLVERR. Optional byte strobes are enabled by AXIL_MEM_STRB_EN.
module axil_slave_mem #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input logic             clk,
  input logic             reset,
  axil_slave_mem_if.slave s
);
  localparam int          IDX_W       = $clog2(DEPTH);
  localparam logic [31:0] SPAN        = 32'(4 * DEPTH);
  localparam logic [3:0]  RD_LAT_C    = 4'(RD_LAT);
  localparam logic [3:0]  WR_LAT_C    = 4'(WR_LAT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_hit(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN) && (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read channel ----------------
  r_state_t         r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      ar_addr_q;
  logic [31:0]      rd_addr;
  logic             rd_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;

  // With zero read latency the sample happens on the AR handshake itself,
  // so the live bus address is used while idle.
  assign rd_addr     = (r_state == R_IDLE) ? s.s_araddr : ar_addr_q;
  assign rd_hit      = addr_hit(rd_addr);
  assign rd_idx      = addr_idx(rd_addr);
  assign rd_word     = rd_hit ? mem[rd_idx] : 32'h0;
  assign s.s_arready = (r_state == R_IDLE) && !reset;

  // Read FSM: accept AR, count wait states, present and hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= 4'd0;
      ar_addr_q <= 32'h0;
      s.s_rvalid <= 1'b0;
      s.s_rdata  <= 32'h0;
      s.s_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s.s_arvalid) begin
            ar_addr_q <= s.s_araddr;
            if (RD_LAT == 0) begin
              r_state    <= R_RESP;
              s.s_rvalid <= 1'b1;
              s.s_rdata  <= rd_word;
              s.s_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
              r_cnt   <= RD_LAT_C;
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state    <= R_RESP;
            s.s_rvalid <= 1'b1;
            s.s_rdata  <= rd_word;
            s.s_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_RESP: begin
          if (s.s_rready) begin
            s.s_rvalid <= 1'b0;
            r_state    <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t         w_state;
  logic [3:0]       w_cnt;
  logic             aw_held;
  logic             w_held;
  logic [31:0]      aw_addr_q;
  logic [31:0]      w_data_q;
  logic             aw_fire;
  logic             w_fire;
  logic             aw_have;
  logic             w_have;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             wr_hit;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_commit;
`ifdef AXIL_MEM_STRB_EN
  logic [3:0]       w_strb_q;
  logic [3:0]       wr_strb;
`endif

  assign s.s_awready = (w_state == W_IDLE) && !aw_held && !reset;
  assign s.s_wready  = (w_state == W_IDLE) && !w_held && !reset;
  assign aw_fire     = s.s_awvalid && s.s_awready;
  assign w_fire      = s.s_wvalid && s.s_wready;
  assign aw_have     = aw_held || aw_fire;
  assign w_have      = w_held || w_fire;
  // A channel captured this very cycle has not been latched yet, so fall
  // back to the bus value until the held copy exists.
  assign wr_addr     = aw_held ? aw_addr_q : s.s_awaddr;
  assign wr_data     = w_held ? w_data_q : s.s_wdata;
`ifdef AXIL_MEM_STRB_EN
  assign wr_strb     = w_held ? w_strb_q : s.s_wstrb;
`endif
  assign wr_hit      = addr_hit(wr_addr);
  assign wr_idx      = addr_idx(wr_addr);
  // Commit happens on the edge that enters W_RESP; reset suppresses it.
  assign wr_commit   = !reset &&
                       (((w_state == W_IDLE) && aw_have && w_have && (WR_LAT == 0)) ||
                        ((w_state == W_WAIT) && (w_cnt == 4'd1)));

  // Write FSM: collect AW and W in any order, count wait states, hold B.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      w_cnt      <= 4'd0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= 32'h0;
      w_data_q   <= 32'h0;
`ifdef AXIL_MEM_STRB_EN
      w_strb_q   <= 4'h0;
`endif
      s.s_bvalid <= 1'b0;
      s.s_bresp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s.s_awaddr;
          end
          if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= s.s_wdata;
`ifdef AXIL_MEM_STRB_EN
            w_strb_q <= s.s_wstrb;
`endif
          end
          if (aw_have && w_have) begin
            if (WR_LAT == 0) begin
              w_state    <= W_RESP;
              s.s_bvalid <= 1'b1;
              s.s_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
              w_cnt   <= WR_LAT_C;
              w_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          w_cnt <= w_cnt - 4'd1;
          if (w_cnt == 4'd1) begin
            w_state    <= W_RESP;
            s.s_bvalid <= 1'b1;
            s.s_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s.s_bready) begin
            s.s_bvalid <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory array update; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_commit && wr_hit) begin
`ifdef AXIL_MEM_STRB_EN
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
`else
      mem[wr_idx] <= wr_data;
`endif
    end
  end
endmodule

// File: doc/axil_slave_mem.md
Name: axil_slave_mem

Overview:
- AXI-Lite slave memory that sits directly downstream of the DMA master.
- Accepts the master's AR/R and AW/W/B channels and serves both the source and destination address windows.
- Supplies RDATA/RVALID, AWREADY/WREADY and BVALID with programmable wait states, so DMA throughput and backpressure paths can be exercised.
- Also used as the system scratch RAM.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..1024.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- RD_LAT, 2, wait cycles between AR handshake and RVALID assertion; 0..15.
- WR_LAT, 1, wait cycles between capturing both AW and W and BVALID assertion; 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_araddr  in  32  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response: 00 OKAY, 10 SLVERR
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_awaddr  in  32  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_wstrb  in  4  byte strobes; present only with AXIL_MEM_STRB_EN

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: s_rvalid=0, s_bvalid=0, s_rresp=00, s_bresp=00, s_rdata=0. The ready outputs are 0 while reset is high.
- Memory array is not reset.
- Reset asserted mid-transaction: both FSMs return to IDLE, in-flight transactions are dropped, no memory write is committed, and all valids are low on the next cycle.
- Address decode, applied to both channels: hit when BASE_ADDR <= addr < BASE_ADDR+4*DEPTH and addr[1:0]==00. Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
- Address miss or misalignment gives resp=10 (SLVERR): a read returns rdata=0, a write leaves memory unchanged.
- Read FSM, states R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: s_arready=1. When s_arvalid is high, latch the address and load the counter with RD_LAT. Go to R_WAIT, or straight to R_RESP if RD_LAT=0.
  - R_WAIT: decrement the counter; at 0, sample memory into s_rdata and go to R_RESP.
  - R_RESP: s_rvalid=1 and s_rdata/s_rresp held stable until s_rready is high, then R_IDLE.
  - Timing: RVALID rises RD_LAT+1 cycles after the AR handshake cycle. Next AR is accepted no earlier than the cycle after the R handshake.
- Write FSM, states W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: s_awready = !aw_held and s_wready = !w_held. AW and W may complete in any order or in the same cycle; each is latched independently.
  - When both are held, load the counter with WR_LAT and go to W_WAIT, or straight to W_RESP if WR_LAT=0.
  - Memory is written on the cycle of entry to W_RESP.
  - W_RESP: s_bvalid=1 held until s_bready is high, then clear the held flags and go to W_IDLE.
- Simultaneous read sample and write commit to the same word: the read returns the old data; the write takes effect the following cycle.
- Read and write FSMs are fully independent; no arbitration stalls.
- s_bresp and s_rresp never take the values 01 or 11.

Optional Feature:
- AXIL_MEM_STRB_EN defined: the s_wstrb port exists, and byte lane k (data bits [8k+7:8k]) is written only when s_wstrb[k]=1. s_wstrb is latched together with W. wstrb=0000 still returns OKAY and leaves the word unchanged.
- Not defined: no s_wstrb port; every write updates all 32 bits.

Test Plan:
- Defaults: write 32'hDEADBEEF to BASE+8 with AW and W in the same cycle -> BVALID 2 cycles after capture, bresp=00. Then read BASE+8 -> RVALID 3 cycles after AR handshake, rdata=32'hDEADBEEF, rresp=00.
- AW presented 3 cycles before W, then the reverse order -> awready drops after capture, no BVALID before W is captured, data lands at the correct word in both orders.
- s_bready held 0 for 5 cycles, s_rready held 0 for 5 cycles -> bvalid/rvalid stay high with rdata/resp stable; exactly one transaction completes each.
- Read BASE+4*DEPTH and read BASE+2 -> rresp=10, rdata=0. Write 32'h12345678 to BASE+4*DEPTH -> bresp=10, and every in-range word is unchanged on readback.
- AXIL_MEM_STRB_EN: word preset to 32'hAABBCCDD, write 32'h11223344 with wstrb=0101 -> readback 32'hAA22CC44.
- Reset asserted during R_WAIT and during W_WAIT -> rvalid/bvalid stay 0, the target word keeps its old value, and the next transaction completes normally.
